// File: rtl/fifo_word_unpacker.sv
// fifo_word_unpacker
// Drains a synchronous FIFO read port (dout valid the cycle after rd_en) and
// splits each wide word into RATIO narrow elements on a valid/ready stream.
// A one-word prefetch register keeps the stream bubble-free while the FIFO
// has data.
//
// Build option: define UNPACK_MSB_FIRST_EN to emit the most significant
// slice of each word first (out_last still marks the final element).
module fifo_word_unpacker #(
    parameter int IN_WIDE  = 64,
    parameter int OUT_WIDE = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fifo_empty,
    output logic                fifo_rd_en,
    input  logic [IN_WIDE-1:0]  fifo_dout,
    output logic [OUT_WIDE-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy
);

    localparam int RATIO    = IN_WIDE / OUT_WIDE;
    localparam int IDX_WIDE = $clog2(RATIO);
    localparam logic [IDX_WIDE-1:0] IDX_LAST = IDX_WIDE'(RATIO - 1);

    generate
        if (RATIO < 2 || (IN_WIDE % OUT_WIDE) != 0) begin : g_bad_cfg
            $error("fifo_word_unpacker: IN_WIDE must be a multiple of OUT_WIDE with ratio >= 2");
        end
    endgenerate

    // A word viewed as an array of output elements, element 0 in the LSBs.
    typedef logic [RATIO-1:0][OUT_WIDE-1:0] word_t;

    word_t               word_buf;
    word_t               pf_buf;
    logic                word_valid;
    logic                pf_valid;
    logic                rd_pending;
    logic [IDX_WIDE-1:0] idx;

    logic [1:0]          held;
    logic                accept;
    logic                at_last;
    logic                free;
    logic [IDX_WIDE-1:0] sel;

    // Words owned by this block: being sliced, prefetched, or on the FIFO bus.
    assign held    = 2'(word_valid) + 2'(pf_valid) + 2'(rd_pending);
    assign accept  = word_valid && out_ready;
    assign at_last = (idx == IDX_LAST);
    assign free    = accept && at_last;

    // Read only when a slot is guaranteed for the returning word; held low in
    // reset so the FIFO is never popped into a block that would discard it.
    assign fifo_rd_en = rst_n && !fifo_empty && (held < 2'd2);

`ifdef UNPACK_MSB_FIRST_EN
    assign sel = IDX_LAST - idx;
`else
    assign sel = idx;
`endif

    assign out_data  = word_buf[sel];
    assign out_valid = word_valid;
    assign out_last  = word_valid && at_last;
    assign busy      = word_valid | pf_valid | rd_pending;

    // Word capture, prefetch promotion and slice index advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_buf   <= '0;
            pf_buf     <= '0;
            word_valid <= 1'b0;
            pf_valid   <= 1'b0;
            rd_pending <= 1'b0;
            idx        <= '0;
        end else begin
            rd_pending <= fifo_rd_en;
            if (rd_pending) begin
                if ((!word_valid || free) && !pf_valid) begin
                    // Nothing queued ahead: the returning word goes straight to slicing.
                    word_buf   <= fifo_dout;
                    word_valid <= 1'b1;
                    idx        <= '0;
                end else if (free && pf_valid) begin
                    // Word retires this cycle: promote prefetch, refill it from the FIFO.
                    word_buf <= pf_buf;
                    pf_buf   <= fifo_dout;
                    idx      <= '0;
                end else begin
                    // Current word still in progress: park the new one. free is 0 here.
                    pf_buf   <= fifo_dout;
                    pf_valid <= 1'b1;
                    if (accept) idx <= idx + IDX_WIDE'(1);
                end
            end else if (free) begin
                idx <= '0;
                if (pf_valid) begin
                    word_buf <= pf_buf;
                    pf_valid <= 1'b0;
                end else begin
                    word_valid <= 1'b0;
                end
            end else if (accept) begin
                idx <= idx + IDX_WIDE'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Bench for fifo_word_unpacker: a queue-based FIFO and element scoreboard
// checked every cycle, plus directed scenarios with literal expectations.
module tb_fifo_word_unpacker;

    localparam int IN_W  = 64;
    localparam int OUT_W = 16;
    localparam int RAT   = IN_W / OUT_W;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             last;
    } elem_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              fifo_empty = 1'b1;
    logic              fifo_rd_en;
    logic [IN_W-1:0]   fifo_dout = '0;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int reads  = 0;

    logic [IN_W-1:0] fifo_q[$];
    elem_t           exp_q[$];

    always #5 clk = ~clk;

    fifo_word_unpacker #(.IN_WIDE(IN_W), .OUT_WIDE(OUT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Element j (in emission order) of a word.
    function automatic logic [OUT_W-1:0] slice_of(input logic [IN_W-1:0] w, input int j);
`ifdef UNPACK_MSB_FIRST_EN
        return w[(RAT-1-j)*OUT_W +: OUT_W];
`else
        return w[j*OUT_W +: OUT_W];
`endif
    endfunction

    // Test word k carries elements 4k+1 .. 4k+4 from LSB upward.
    function automatic logic [IN_W-1:0] mk_word(input int k);
        return {16'(4*k+4), 16'(4*k+3), 16'(4*k+2), 16'(4*k+1)};
    endfunction

    // Hand-derived emission value of element j of test word k.
    function automatic logic [OUT_W-1:0] exp_elem(input int k, input int j);
`ifdef UNPACK_MSB_FIRST_EN
        return 16'(4*k + (RAT-1-j) + 1);
`else
        return 16'(4*k + j + 1);
`endif
    endfunction

    task automatic push(input logic [IN_W-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // FIFO model, scoreboard update, then per-cycle comparison once outputs settle.
    always @(posedge clk) begin
        logic [IN_W-1:0] w;
        if (rst_n && out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (!rst_n) exp_q.delete();
        if (fifo_rd_en && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            fifo_dout <= w;
            reads++;
            if (rst_n)
                for (int j = 0; j < RAT; j++) exp_q.push_back('{slice_of(w, j), j == RAT-1});
        end
        fifo_empty <= (fifo_q.size() == 0);
        #2;
        if (!rst_n) begin
            chk("reset_outputs", {fifo_rd_en, out_valid, out_last, busy, out_data}, 0);
        end else begin
            chk("rd_while_empty", fifo_rd_en && fifo_empty, 0);
            chk("words_held_le2", ((exp_q.size() + RAT - 1) / RAT) <= 2, 1);
            chk("busy", busy, exp_q.size() > 0);
            if (out_valid) begin
                if (exp_q.size() == 0) chk("unexpected_valid", out_valid, 0);
                else begin
                    chk("stream_data", out_data, exp_q[0].data);
                    chk("stream_last", out_last, exp_q[0].last);
                end
            end else begin
                chk("last_without_valid", out_last, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;
        int r0;
        logic [IN_W-1:0] wa;
        logic [IN_W-1:0] wb;
        logic [IN_W-1:0] wc;

        // T1: single pre-loaded word, latency and order.
        repeat (2) @(negedge clk);
        push(64'h0004_0003_0002_0001);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t1_rd_en_in_reset", fifo_rd_en, 0);
        chk("t1_outs_in_reset", {out_valid, out_last, busy, out_data}, 0);
        rst_n = 1'b1;
        #1 chk("t1_rd_en_cycle0", fifo_rd_en, 1);
        @(negedge clk);
        chk("t1_valid_cycle1", out_valid, 0);
        chk("t1_busy_cycle1", busy, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_valid", out_valid, 1);
            chk("t1_data", out_data, exp_elem(0, i));
            chk("t1_last", out_last, i == 3);
        end
        @(negedge clk);
        chk("t1_valid_after", out_valid, 0);
        chk("t1_busy_after", busy, 0);
`ifdef UNPACK_MSB_FIRST_EN
        chk("t1_pin_first", exp_elem(0, 0), 16'h0004);
`else
        chk("t1_pin_first", exp_elem(0, 0), 16'h0001);
`endif

        // T2: three words back-to-back, 12 elements without a bubble.
        for (int k = 0; k < 3; k++) push(mk_word(k));
        t = 0;
        while (!out_valid && t < 10) begin @(negedge clk); t++; end
        for (int i = 0; i < 12; i++) begin
            chk("t2_no_bubble", out_valid, 1);
            chk("t2_data", out_data, exp_elem(i / 4, i % 4));
            @(negedge clk);
        end
        chk("t2_valid_after", out_valid, 0);

        // T3: downstream stalled with 5 words queued.
        out_ready = 1'b0;
        r0 = reads;
        for (int k = 0; k < 5; k++) push(mk_word(k));
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_data", out_data, exp_elem(0, 0));
            chk("t3_no_read", fifo_rd_en, 0);
            @(negedge clk);
        end
        chk("t3_reads_issued", reads - r0, 2);
        out_ready = 1'b1;
        n = 0;
        t = 0;
        while (n < 20 && t < 60) begin
            if (out_valid) begin
                chk("t3_resume_data", out_data, exp_elem(n / 4, n % 4));
                n++;
            end
            @(negedge clk);
            t++;
        end
        chk("t3_elems_drained", n, 20);
        repeat (3) @(negedge clk);

        // T4: empty FIFO, ready toggling.
        for (int i = 0; i < 20; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("t4_no_read", fifo_rd_en, 0);
            chk("t4_no_valid", out_valid, 0);
        end

        // T5: reset in the middle of a word.
        out_ready = 1'b1;
        wa = {16'h00A4, 16'h00A3, 16'h00A2, 16'h00A1};
        wb = {16'h00B4, 16'h00B3, 16'h00B2, 16'h00B1};
        wc = {16'h00C4, 16'h00C3, 16'h00C2, 16'h00C1};
        push(wa);
        push(wb);
        push(wc);
        t = 0;
`ifdef UNPACK_MSB_FIRST_EN
        while (!(out_valid && out_data == 16'h00A2) && t < 20) begin @(negedge clk); t++; end
`else
        while (!(out_valid && out_data == 16'h00A3) && t < 20) begin @(negedge clk); t++; end
`endif
        chk("t5_reached_idx2", out_valid, 1);
        rst_n = 1'b0;
        #1 chk("t5_outs_zero", {fifo_rd_en, out_valid, out_last, busy, out_data}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        while (!out_valid && t < 10) begin @(negedge clk); t++; end
        chk("t5_valid_after_reset", out_valid, 1);
`ifdef UNPACK_MSB_FIRST_EN
        chk("t5_restart_slice0", out_data, 16'h00C4);
`else
        chk("t5_restart_slice0", out_data, 16'h00C1);
`endif
        t = 0;
        while ((busy || fifo_q.size() > 0) && t < 40) begin @(negedge clk); t++; end
        chk("t5_idle", {busy, out_valid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
